// File: rtl/ad73_sport_tx.sv
`default_nettype none
// ============================================================================
// Module   : ad73_sport_tx
// Brief    : AD73xx codec serial-port transmitter. Buffers words in a small
//            FIFO and frames them onto SDIFS/SDI on rising edges of the
//            codec SCLK, which is oversampled in the clk domain.
// Revision : 1.0  initial release
// ============================================================================
module ad73_sport_tx #(
    parameter int WORD_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_SCLKS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              enable,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              se,
    output logic              sdifs,
    output logic              sdi,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WORD_W - 1);
    // The IDLE period before the next sync counts as the last idle period.
    localparam logic [3:0]         c_GAP_LOAD = (GAP_SCLKS > 0) ? 4'(GAP_SCLKS - 1) : 4'd0;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FSYNC = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic                   r_sclk_hist;
    logic                   w_sclk_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_hist;

    logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic               r_tx_ready;
    logic               w_wr;
    logic               w_pop;
    logic               w_empty;
    logic [WORD_W-1:0]  w_head;

    assign w_empty = (r_count == '0);
    assign w_wr    = tx_valid && r_tx_ready;
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_tx_ready <= (w_count_next != c_FULL);
        end
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WORD_W-1:0]  r_sr;
    logic [WORD_W-1:0]  w_sr_next;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_next;
    logic [3:0]         r_gap_cnt;
    logic [3:0]         w_gap_cnt_next;
    logic               r_sdifs;
    logic               w_sdifs_next;
    logic               r_sdi;
    logic               w_sdi_next;
    logic               r_frame_done;
    logic               w_frame_done_next;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        w_frame_cnt_next;
    logic               r_se;

    always_comb begin
        w_state_next      = r_state;
        w_sr_next         = r_sr;
        w_bit_cnt_next    = r_bit_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_sdifs_next      = r_sdifs;
        w_sdi_next        = r_sdi;
        w_frame_done_next = 1'b0;
        w_frame_cnt_next  = r_frame_cnt;
        w_pop             = 1'b0;
        if (w_sclk_rise) begin
            case (r_state)
                c_IDLE: begin
                    if (enable && !w_empty && (r_gap_cnt == 4'd0)) begin
                        w_pop        = 1'b1;
                        w_sr_next    = w_head;
                        w_sdifs_next = 1'b1;
                        w_sdi_next   = 1'b0;
                        w_state_next = c_FSYNC;
                    end
                end
                c_FSYNC: begin
                    w_sdifs_next   = 1'b0;
                    w_sdi_next     = r_sr[WORD_W-1];
                    w_bit_cnt_next = c_BIT_LAST;
                    w_state_next   = c_SHIFT;
                end
                c_SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        w_sr_next      = {r_sr[WORD_W-2:0], 1'b0};
                        w_sdi_next     = r_sr[WORD_W-2];
                        w_bit_cnt_next = r_bit_cnt - 1'b1;
                    end else begin
                        w_frame_done_next = 1'b1;
                        w_frame_cnt_next  = r_frame_cnt + 16'd1;
                        w_gap_cnt_next    = c_GAP_LOAD;
                        w_sdi_next        = 1'b0;
                        if ((GAP_SCLKS == 0) && !w_empty && enable) begin
                            // Back-to-back: this edge doubles as the next sync.
                            w_pop        = 1'b1;
                            w_sr_next    = w_head;
                            w_sdifs_next = 1'b1;
                            w_state_next = c_FSYNC;
                        end else if (c_GAP_LOAD != 4'd0) begin
                            w_state_next = c_GAP;
                        end else begin
                            w_state_next = c_IDLE;
                        end
                    end
                end
                c_GAP: begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                    if (r_gap_cnt == 4'd1) begin
                        w_state_next = c_IDLE;
                    end
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= 4'd0;
            r_sdifs      <= 1'b0;
            r_sdi        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_se         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sr         <= w_sr_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_sdifs      <= w_sdifs_next;
            r_sdi        <= w_sdi_next;
            r_frame_done <= w_frame_done_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_se         <= enable || (w_state_next != c_IDLE);
        end
    end

    assign tx_ready   = r_tx_ready;
    assign se         = r_se;
    assign sdifs      = r_sdifs;
    assign sdi        = r_sdi;
    assign busy       = (r_state != c_IDLE) || !w_empty;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ad73_sport_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad73_sport_tx
// Brief    : Self-checking bench for ad73_sport_tx; serial stream compared
//            against a word-level framing model, one DUT per gap setting.
// Revision : 1.0  initial release
// ============================================================================
module tb_ad73_sport_tx;

    logic        clk = 1'b0;
    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1, enable_g = 1'b1;
    logic [15:0] tx_data = 16'd0, tx_data_g = 16'd0;
    logic        tx_valid = 1'b0, tx_valid_g = 1'b0;
    logic        tx_ready, se, sdifs, sdi, busy, frame_done;
    logic        tx_ready_g, se_g, sdifs_g, sdi_g, busy_g, frame_done_g;
    logic [15:0] frame_cnt, frame_cnt_g;

    int checks = 0, fails = 0;
    int exp_cnt = 0, exp_cnt_g = 0, done_a = 0, done_g = 0;
    logic mon_fs[$], mon_d[$], mon_fs_g[$], mon_d_g[$];

    always #10.417 clk = ~clk;
    always #61.035 sclk = ~sclk;

    ad73_sport_tx #(.WORD_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2), .GAP_SCLKS(0)) u_dut (
        .clk(clk), .rst(rst), .sclk(sclk), .enable(enable), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .se(se), .sdifs(sdifs), .sdi(sdi),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt));

    ad73_sport_tx #(.WORD_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2), .GAP_SCLKS(3)) u_dut_gap (
        .clk(clk), .rst(rst), .sclk(sclk), .enable(enable_g), .tx_data(tx_data_g),
        .tx_valid(tx_valid_g), .tx_ready(tx_ready_g), .se(se_g), .sdifs(sdifs_g), .sdi(sdi_g),
        .busy(busy_g), .frame_done(frame_done_g), .frame_cnt(frame_cnt_g));

    // One sample per SCLK period, taken before the edge's update reaches the pins.
    always @(posedge sclk) begin
        #1;
        mon_fs.push_back(sdifs);
        mon_d.push_back(sdi);
        mon_fs_g.push_back(sdifs_g);
        mon_d_g.push_back(sdi_g);
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_a++;
        if (frame_done_g === 1'b1) done_g++;
    end

    // Reference: each word is one sync period then 16 bits MSB first, with
    // 'gap' idle periods between frames and all-zero lines outside frames.
    function automatic int stream_errs(input bit g, input logic [15:0] words[$], input int gap);
        logic efs[$];
        logic ed[$];
        logic cfs[$];
        logic cd[$];
        int   s;
        int   errs;
        foreach (words[k]) begin
            if (k > 0) begin
                repeat (gap) begin efs.push_back(1'b0); ed.push_back(1'b0); end
            end
            efs.push_back(1'b1);
            ed.push_back(1'b0);
            for (int b = 15; b >= 0; b--) begin
                efs.push_back(1'b0);
                ed.push_back(words[k][b]);
            end
        end
        if (g) begin cfs = mon_fs_g; cd = mon_d_g; end
        else   begin cfs = mon_fs;   cd = mon_d;   end
        s = -1;
        for (int i = 0; i < cfs.size(); i++) begin
            if (cfs[i] === 1'b1 && s < 0) s = i;
        end
        if (s < 0) return efs.size();
        errs = 0;
        for (int i = 0; i < cfs.size(); i++) begin
            logic xf, xd;
            if (i >= s && (i - s) < efs.size()) begin xf = efs[i-s]; xd = ed[i-s]; end
            else begin xf = 1'b0; xd = 1'b0; end
            if (cfs[i] !== xf || cd[i] !== xd) errs++;
        end
        if (cfs.size() < s + efs.size()) errs += s + efs.size() - cfs.size();
        return errs;
    endfunction

    task automatic clear_mon();
        mon_fs.delete(); mon_d.delete(); mon_fs_g.delete(); mon_d_g.delete();
    endtask

    task automatic push(input bit g, input logic [15:0] w);
        int n = 0;
        while ((g ? tx_ready_g : tx_ready) !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (g) begin tx_data_g = w; tx_valid_g = 1'b1; end
        else   begin tx_data = w;   tx_valid = 1'b1;   end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_valid_g = 1'b0;
    endtask

    task automatic wait_idle(input bit g, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if ((g ? busy_g : busy) === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge sclk);
        @(negedge clk);
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (sdifs === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (tx_ready !== 1'b1)    begin $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); fails++; end
        checks++; if (se !== 1'b0)          begin $display("FAIL reset_se: got %b expected 0", se); fails++; end
        checks++; if (sdifs !== 1'b0 || sdi !== 1'b0) begin $display("FAIL reset_serial: sdifs %b sdi %b expected 0 0", sdifs, sdi); fails++; end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin $display("FAIL reset_status: busy %b frame_done %b expected 0 0", busy, frame_done); fails++; end
        checks++; if (frame_cnt !== 16'd0 || frame_cnt_g !== 16'd0) begin $display("FAIL reset_frame_cnt: got %0h/%0h expected 0", frame_cnt, frame_cnt_g); fails++; end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [15:0] wq[$];
        bit ok;
        int d0, errs;
        clear_mon();
        d0 = done_a;
        wq.push_back(16'hA5C3);
        push(1'b0, 16'hA5C3);
        wait_idle(1'b0, ok);
        exp_cnt++;
        errs = stream_errs(1'b0, wq, 0);
        checks++; if (!ok) begin $display("FAIL single_timeout: busy %b expected 0", busy); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL single_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); fails++; end
        checks++; if (done_a - d0 !== 1) begin $display("FAIL single_frame_done: got %0d pulses expected 1", done_a - d0); fails++; end
        checks++; if (sdi !== 1'b0 || busy !== 1'b0) begin $display("FAIL single_after: sdi %b busy %b expected 0 0", sdi, busy); fails++; end
    endtask

    task automatic test_back_to_back();
        logic [15:0] wq[$];
        bit ok;
        int d0, errs;
        clear_mon();
        d0 = done_a;
        wq.push_back(16'h0001); wq.push_back(16'h8000); wq.push_back(16'hFFFF);
        foreach (wq[i]) push(1'b0, wq[i]);
        wait_idle(1'b0, ok);
        exp_cnt += 3;
        errs = stream_errs(1'b0, wq, 0);
        checks++; if (!ok) begin $display("FAIL b2b_timeout: busy %b expected 0", busy); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL b2b_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); fails++; end
        checks++; if (done_a - d0 !== 3) begin $display("FAIL b2b_frame_done: got %0d pulses expected 3", done_a - d0); fails++; end
    endtask

    task automatic test_random_words();
        logic [15:0] wq[$];
        bit ok;
        int errs, n;
        clear_mon();
        n = $urandom_range(7, 4);
        for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
        foreach (wq[i]) push(1'b0, wq[i]);
        wait_idle(1'b0, ok);
        exp_cnt += n;
        errs = stream_errs(1'b0, wq, 0);
        checks++; if (!ok) begin $display("FAIL random_timeout: busy %b expected 0", busy); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL random_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin $display("FAIL random_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); fails++; end
    endtask

    task automatic test_fifo_full();
        logic [15:0] wq[$];
        bit ok;
        int errs;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
        for (int i = 0; i < 5; i++) begin
            tx_data = wq[i];
            tx_valid = 1'b1;
            @(negedge clk);
            checks++; if (tx_ready !== (i < 3)) begin $display("FAIL full_tx_ready_%0d: got %b expected %b", i, tx_ready, (i < 3)); fails++; end
        end
        tx_valid = 1'b0;
        checks++; if (se !== 1'b0) begin $display("FAIL full_se: got %b expected 0", se); fails++; end
        wq.pop_back();
        enable = 1'b1;
        wait_idle(1'b0, ok);
        exp_cnt += 4;
        errs = stream_errs(1'b0, wq, 0);
        checks++; if (!ok) begin $display("FAIL full_timeout: busy %b expected 0", busy); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL full_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (frame_cnt !== 16'(exp_cnt)) begin $display("FAIL full_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); fails++; end
    endtask

    task automatic test_enable_drop();
        logic [15:0] wq[$];
        bit ok, done_ok;
        int errs;
        clear_mon();
        wq.push_back(16'h1234);
        push(1'b0, 16'h1234);
        push(1'b0, 16'($urandom));
        wait_fs(ok);
        repeat (9) @(posedge sclk);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (se !== 1'b1) begin $display("FAIL drop_se_held: got %b expected 1", se); fails++; end
        done_ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (frame_cnt === 16'(exp_cnt + 1)) begin done_ok = 1'b1; break; end
        end
        exp_cnt++;
        repeat (25) @(posedge sclk);
        @(negedge clk);
        errs = stream_errs(1'b0, wq, 0);
        checks++; if (!(ok && done_ok)) begin $display("FAIL drop_timeout: sync %b done %b expected 1 1", ok, done_ok); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL drop_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (se !== 1'b0 || busy !== 1'b1) begin $display("FAIL drop_after: se %b busy %b expected 0 1", se, busy); fails++; end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int nfs;
        enable = 1'b1;
        push(1'b0, 16'($urandom));
        push(1'b0, 16'($urandom));
        wait_fs(ok);
        repeat (7) @(posedge sclk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (!ok) begin $display("FAIL rstmid_timeout: no sync seen, expected 1"); fails++; end
        checks++; if (sdifs !== 1'b0 || sdi !== 1'b0 || se !== 1'b0) begin $display("FAIL rstmid_serial: sdifs %b sdi %b se %b expected 0 0 0", sdifs, sdi, se); fails++; end
        checks++; if (tx_ready !== 1'b1 || frame_cnt !== 16'd0) begin $display("FAIL rstmid_state: tx_ready %b frame_cnt %0d expected 1 0", tx_ready, frame_cnt); fails++; end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        clear_mon();
        repeat (40) @(posedge sclk);
        @(negedge clk);
        nfs = 0;
        foreach (mon_fs[i]) if (mon_fs[i] === 1'b1) nfs++;
        checks++; if (nfs !== 0 || frame_cnt !== 16'(exp_cnt)) begin $display("FAIL rstmid_no_resume: %0d syncs frame_cnt %0d expected 0 0", nfs, frame_cnt); fails++; end
    endtask

    task automatic test_gap();
        logic [15:0] wq[$];
        bit ok;
        int d0, errs;
        clear_mon();
        d0 = done_g;
        wq.push_back(16'($urandom) | 16'h0001);
        wq.push_back(16'($urandom) | 16'h8000);
        foreach (wq[i]) push(1'b1, wq[i]);
        wait_idle(1'b1, ok);
        exp_cnt_g += 2;
        errs = stream_errs(1'b1, wq, 3);
        checks++; if (!ok) begin $display("FAIL gap_timeout: busy %b expected 0", busy_g); fails++; end
        checks++; if (errs !== 0) begin $display("FAIL gap_stream: %0d bit errors, expected 0", errs); fails++; end
        checks++; if (frame_cnt_g !== 16'(exp_cnt_g)) begin $display("FAIL gap_frame_cnt: got %0d expected %0d", frame_cnt_g, exp_cnt_g); fails++; end
        checks++; if (done_g - d0 !== 2) begin $display("FAIL gap_frame_done: got %0d pulses expected 2", done_g - d0); fails++; end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_words();
        test_fifo_full();
        test_enable_drop();
        test_reset_mid_frame();
        test_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
